i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) responder, the bus-side counterpart of the team's I2C master handler. Decodes START/STOP, matches a 7-bit device address, and accepts a 16-bit register pointer (high byte first, matching the master's 16-bit address mode). Writes and reads a fabric-side byte memory through a simple synchronous port, auto-incrementing the pointer. Serves as a loopback target for the master and for emulating EEPROM-style peripherals.

## Interface
- DEV_ADDR, 7'h50: 7-bit device address answered.
- MEM_AW, 8: memory index width; index = pointer[MEM_AW-1:0].
- FILTER_LEN, 3: cycles a synchronized SCL/SDA level must be stable before it is accepted.

- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- i2c_scl  input  1  bus clock; no clock stretching
- i2c_sda  inout  1  open-drain; drives 1'b0 or 1'bz only
- wr_en  output  1  one-cycle write strobe
- wr_addr  output  MEM_AW  write index
- wr_data  output  8  write byte
- rd_en  output  1  one-cycle read strobe
- rd_addr  output  MEM_AW  read index
- rd_data  input  8  read byte, valid the cycle after rd_en
- busy  output  1  high from matched address until STOP/START/abort

## Operation
- Front end: 2-FF synchronizer per line, then FILTER_LEN stability filter; filtered levels give scl_rise, scl_fall, START (SDA fall, SCL high), STOP (SDA rise, SCL high).
- Bits sampled on scl_rise, MSB first; SDA changes only on scl_fall.
- States: S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_REG_HI, S_ACK_HI, S_REG_LO, S_ACK_LO, S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK, S_IGNORE.
- S_IDLE -> S_DEV_ADDR on START. After 8 bits: address match -> S_ACK_DEV; mismatch -> S_IGNORE (no ACK).
- S_ACK_DEV: drive ACK low for bit 9. R/W=0 -> S_REG_HI; R/W=1 -> issue rd_en at current pointer, then S_RD_DATA (current-address read).
- S_REG_HI/S_REG_LO: collect pointer bytes, ACK each. The pointer is committed only when the low byte completes; a partial pointer is discarded.
- S_WR_DATA: on byte 8 complete, pulse wr_en with wr_addr = pointer index and ACK. Pointer +1, wrapping at 16 bits.
- S_RD_DATA: shift register loads rd_data in the cycle after rd_en and drives bit 7 on the ACK-phase scl_fall. After 8 bits, release SDA -> S_RD_ACK and increment the pointer.
- S_RD_ACK: master ACK (0) -> rd_en at new pointer, back to S_RD_DATA. NACK (1) -> S_IGNORE.
- START in any state -> S_DEV_ADDR, bit counter cleared, partial byte dropped. This covers repeated START for random read.
- STOP in any state -> S_IDLE, SDA released.
- The pointer persists across transactions and is reset to 0.

## Timing
- Input latency 2 + FILTER_LEN cycles. clk must be at least 16× the SCL rate; the master's SCL period far exceeds this.
- SDA output asserts or releases 1 cycle after the filtered scl_fall.
- wr_en occurs 1 cycle after the 8th scl_rise of a data byte.
- rd_en occurs 1 cycle after the ACK-bit scl_rise; rd_data is captured the next cycle, well before scl_fall.
- Reset values: SDA released (z), wr_en=0, rd_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, pointer=0, state S_IDLE.
- Reset mid-transfer releases SDA on the next clk edge. The block then waits for a fresh START; no bus-recovery pulses.
- A START and a STOP cannot be detected in the same cycle, since they are mutually exclusive SDA edges. A START or STOP detected in the same cycle as a byte completion takes priority: no wr_en is issued.

## Structure
- Shared i2c_defs package/header: state encodings, ACK/NACK constants, R/W bit position.
- Sub-module i2c_bus_filter: synchronizer, stability filter, edge and START/STOP detection. Instanced once, outputs level plus event pulses.
- Top holds the FSM, bit counter (0..8), shift register, and pointer.

## Test plan
- Write: START, 0xA0, 0x00, 0x10, 0x11, 0x22, STOP -> ACK on all 5 bytes; wr_en at indices 0x10 and 0x11 with data 0x11 and 0x22.
- Random read: write pointer 0x0010, repeated START, 0xA1, master ACK then NACK -> two rd_en pulses (0x10, 0x11); SDA carries the memory model bytes; ends in S_IGNORE, then S_IDLE on STOP.
- Mismatch: START, 0xA2 -> SDA stays z on bit 9; no strobes; busy=0.
- Wrap: pointer 0xFFFF, write 2 bytes -> wr_addr 0xFF then 0x00 (MEM_AW=8); pointer reads back as 0x0001.
- Abort: START, 0xA0, 0x12, STOP, then current-address read -> pointer unchanged (0x0000 after reset); rd_addr=0x00.
- Reset during S_RD_DATA with SDA driven low -> SDA z within 1 cycle; all outputs at reset values; next START is decoded normally.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: FSM states, ACK/NACK levels, R/W bit position.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDevAddr,
    StAckDev,
    StRegHi,
    StAckHi,
    StRegLo,
    StAckLo,
    StWrData,
    StAckWr,
    StRdData,
    StRdAck,
    StIgnore
  } state_e;

  localparam logic Ack  = 1'b0;
  localparam logic Nack = 1'b1;

  // R/W flag is the LSB of the address byte.
  localparam int unsigned RwBit = 0;

  localparam int unsigned    BitCntW = 4;
  localparam logic [BitCntW-1:0] LastBit = 4'd7;

  // The target counts as busy only once its address has matched.
  function automatic logic state_busy(state_e s);
    return !(s inside {StIdle, StDevAddr, StIgnore});
  endfunction

endpackage

// File: rtl/i2c_bus_filter.sv
// SCL/SDA front end: 2-FF synchronizer, stability filter, edge and START/STOP detection.
module i2c_bus_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int unsigned      CntW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0]  CntMax = CntW'(FILTER_LEN - 1);

  // Bit 0 carries SCL, bit 1 carries SDA.
  logic [1:0]      line_in;
  logic [1:0]      meta_q;
  logic [1:0]      sync_q;
  logic [1:0]      filt_q;
  logic [1:0]      prev_q;
  logic [CntW-1:0] cnt_q [2];

  assign line_in = {sda_i, scl_i};

  // Synchronize both lines and accept a new level only after FILTER_LEN stable cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= 2'b11;
      sync_q   <= 2'b11;
      filt_q   <= 2'b11;
      prev_q   <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] != filt_q[i]) begin
          if (cnt_q[i] == CntMax) begin
            filt_q[i] <= sync_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign sda_o      = filt_q[1];
  assign scl_rise_o =  filt_q[0] & ~prev_q[0];
  assign scl_fall_o = ~filt_q[0] &  prev_q[0];
  // SDA edges only count as START/STOP while SCL has been high on both sides of the edge.
  assign start_o    =  prev_q[1] & ~filt_q[1] & filt_q[0] & prev_q[0];
  assign stop_o     = ~prev_q[1] &  filt_q[1] & filt_q[0] & prev_q[0];

endmodule

// File: rtl/i2c_target.sv
// I2C target with 16-bit register pointer fronting a synchronous byte memory port.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned MEM_AW     = 8,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  output logic              wr_en,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [MEM_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  i2c_bus_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_bus_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (i2c_scl),
    .sda_i     (i2c_sda),
    .sda_o     (sda_f),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  state_e              state_q, state_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [15:0]         ptr_q, ptr_d;
  logic [7:0]          ptr_hi_q, ptr_hi_d;
  logic                sda_low_q, sda_low_d;
  logic                wr_en_q, wr_en_d;
  logic [MEM_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                rd_en_q, rd_en_d;
  logic [MEM_AW-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_cap_q, rd_cap_d;
  logic [7:0]          byte_in;

  assign byte_in = {shift_q[6:0], sda_f};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      ptr_hi_q  <= '0;
      sda_low_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_cap_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      ptr_hi_q  <= ptr_hi_d;
      sda_low_q <= sda_low_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_cap_q  <= rd_cap_d;
    end
  end

  // Bus protocol FSM: next state, pointer handling, memory strobes and SDA drive.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    ptr_hi_d  = ptr_hi_q;
    sda_low_d = sda_low_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    // Read data is valid the cycle after rd_en.
    rd_cap_d  = rd_en_q;

    if (start) begin
      state_d   = StDevAddr;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      rd_cap_d  = 1'b0;
    end else if (stop) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      rd_cap_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sda_low_d = 1'b0;
        end

        StDevAddr, StRegHi, StRegLo, StWrData: begin
          // First fall after an ACK bit ends our ACK drive.
          if (scl_fall) begin
            sda_low_d = 1'b0;
          end
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d = '0;
              if (state_q == StDevAddr) begin
                state_d = (byte_in[7:1] == DEV_ADDR) ? StAckDev : StIgnore;
              end else if (state_q == StRegHi) begin
                ptr_hi_d = byte_in;
                state_d  = StAckHi;
              end else if (state_q == StRegLo) begin
                // Pointer only changes once both bytes have arrived.
                ptr_d   = {ptr_hi_q, byte_in};
                state_d = StAckLo;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q[MEM_AW-1:0];
                wr_data_d = byte_in;
                ptr_d     = ptr_q + 16'd1;
                state_d   = StAckWr;
              end
            end
          end
        end

        StAckDev, StAckHi, StAckLo, StAckWr: begin
          if (scl_fall) begin
            sda_low_d = 1'b1;
          end
          if (scl_rise) begin
            bit_cnt_d = '0;
            if (state_q == StAckDev) begin
              if (shift_q[RwBit]) begin
                rd_en_d   = 1'b1;
                rd_addr_d = ptr_q[MEM_AW-1:0];
                state_d   = StRdData;
              end else begin
                state_d = StRegHi;
              end
            end else if (state_q == StAckHi) begin
              state_d = StRegLo;
            end else begin
              state_d = StWrData;
            end
          end
        end

        StRdData: begin
          if (rd_cap_q) begin
            shift_d = rd_data;
          end
          if (scl_fall) begin
            sda_low_d = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d = '0;
              ptr_d     = ptr_q + 16'd1;
              state_d   = StRdAck;
            end
          end
        end

        StRdAck: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
          end
          if (scl_rise) begin
            if (sda_f == Nack) begin
              state_d = StIgnore;
            end else begin
              rd_en_d   = 1'b1;
              rd_addr_d = ptr_q[MEM_AW-1:0];
              state_d   = StRdData;
            end
          end
        end

        StIgnore: begin
          sda_low_d = 1'b0;
        end

        default: begin
          state_d   = StIdle;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  // Open-drain: only ever pull low or release.
  assign i2c_sda = sda_low_q ? Ack : 1'bz;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = state_busy(state_q);

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench: bit-banged I2C master, byte memory, transaction-level reference model.
module tb_i2c_target;

  localparam int unsigned Q = 10;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  wire  sda_bus;
  assign sda_bus = sda_m ? 1'bz : 1'b0;
  pullup pu_sda (sda_bus);

  logic       wr_en, rd_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  i2c_target #(
    .DEV_ADDR  (7'h50),
    .MEM_AW    (8),
    .FILTER_LEN(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i2c_scl(scl_m),
    .i2c_sda(sda_bus),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy)
  );

  // Fabric-side memory attached to the target.
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (wr_en)   mem[wr_addr]   <= wr_data;
    if (rd_en)   rd_data        <= mem[rd_addr];
  end

  // Strobe monitor.
  logic [15:0] got_wr_q[$];
  logic [7:0]  got_rd_q[$];
  always @(negedge clk) begin
    if (wr_en) got_wr_q.push_back({wr_addr, wr_data});
    if (rd_en) got_rd_q.push_back(rd_addr);
  end

  // Reference model state.
  logic [7:0]  ref_mem [256];
  logic [15:0] ref_ptr = 16'h0000;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  tx_data[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp_v);
    n_checks++;
    if (got != exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wq();
    scl_m = 1'b1; wq();
    wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    b = sda_bus;  wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      b[i] = bt;
    end
    write_bit(ack_bit);
  endtask

  task automatic check_strobes();
    check_eq("wr_count", got_wr_q.size(), exp_wr_q.size());
    for (int i = 0; i < got_wr_q.size() && i < exp_wr_q.size(); i++)
      check_eq("wr_evt", got_wr_q[i], exp_wr_q[i]);
    check_eq("rd_count", got_rd_q.size(), exp_rd_q.size());
    for (int i = 0; i < got_rd_q.size() && i < exp_rd_q.size(); i++)
      check_eq("rd_addr", got_rd_q[i], exp_rd_q[i]);
    got_wr_q.delete();
    exp_wr_q.delete();
    got_rd_q.delete();
    exp_rd_q.delete();
  endtask

  // START, write address, 16-bit pointer; leaves the bus mid-transaction.
  task automatic txn_set_ptr(input logic [15:0] p);
    logic ack;
    bus_start();
    write_byte(8'hA0, ack);
    check_eq("dev_ack", ack, 0);
    check_eq("busy_on", busy, 1);
    write_byte(p[15:8], ack);
    check_eq("ptr_hi_ack", ack, 0);
    write_byte(p[7:0], ack);
    check_eq("ptr_lo_ack", ack, 0);
    ref_ptr = p;
  endtask

  task automatic txn_write(input logic [15:0] p);
    logic ack;
    txn_set_ptr(p);
    foreach (tx_data[i]) begin
      write_byte(tx_data[i], ack);
      check_eq("data_ack", ack, 0);
      ref_mem[ref_ptr[7:0]] = tx_data[i];
      exp_wr_q.push_back({ref_ptr[7:0], tx_data[i]});
      ref_ptr = ref_ptr + 16'd1;
    end
    bus_stop();
    tx_data.delete();
    check_eq("busy_off_wr", busy, 0);
  endtask

  task automatic txn_read(input bit set_ptr, input logic [15:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    if (set_ptr) txn_set_ptr(p);
    bus_start();
    write_byte(8'hA1, ack);
    check_eq("rd_dev_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(ref_ptr[7:0]);
      read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      check_eq("rd_byte", d, ref_mem[ref_ptr[7:0]]);
      ref_ptr = ref_ptr + 16'd1;
    end
    check_eq("busy_after_nack", busy, 0);
    bus_stop();
  endtask

  task automatic txn_mismatch(input logic [6:0] a, input logic rw);
    logic ack;
    bus_start();
    write_byte({a, rw}, ack);
    check_eq("mismatch_nack", ack, 1);
    check_eq("mismatch_busy", busy, 0);
    write_byte(8'($urandom), ack);
    check_eq("mismatch_data_nack", ack, 1);
    bus_stop();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr_en"}, wr_en, 0);
    check_eq({tag, "_rd_en"}, rd_en, 0);
    check_eq({tag, "_wr_addr"}, wr_addr, 0);
    check_eq({tag, "_wr_data"}, wr_data, 0);
    check_eq({tag, "_rd_addr"}, rd_addr, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_sda"}, sda_bus, 1);
  endtask

  initial begin
    logic       ack;
    logic       bt;
    logic [6:0] bad;

    for (int i = 0; i < 256; i++) load_byte(8'(i), 8'($urandom));
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wq();

    // Aborted pointer write leaves the pointer at its reset value.
    bus_start();
    write_byte(8'hA0, ack);
    check_eq("abort_dev_ack", ack, 0);
    write_byte(8'h12, ack);
    check_eq("abort_hi_ack", ack, 0);
    bus_stop();
    txn_read(1'b0, 16'h0000, 1);
    check_strobes();

    // Directed write of two bytes at 0x0010.
    tx_data.push_back(8'h11);
    tx_data.push_back(8'h22);
    txn_write(16'h0010);
    check_strobes();

    // Random read via repeated START.
    txn_read(1'b1, 16'h0010, 2);
    check_strobes();

    // Address mismatch.
    txn_mismatch(7'h51, 1'b0);
    check_strobes();

    // Pointer wrap at 16 bits, then current-address read from 0x0001.
    tx_data.push_back(8'($urandom));
    tx_data.push_back(8'($urandom));
    txn_write(16'hFFFF);
    txn_read(1'b0, 16'h0000, 1);
    check_strobes();

    // Randomized mix.
    for (int it = 0; it < 6; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) tx_data.push_back(8'($urandom));
          txn_write(16'($urandom));
        end
        1: txn_read(1'($urandom), 16'($urandom), int'($urandom_range(1, 3)));
        default: begin
          bad = 7'($urandom);
          if (bad == 7'h50) bad = 7'h2A;
          txn_mismatch(bad, 1'($urandom));
        end
      endcase
      check_strobes();
    end

    // Reset while the target is driving a 0 data bit.
    load_byte(ref_ptr[7:0], 8'h00);
    bus_start();
    write_byte(8'hA1, ack);
    check_eq("rst_dev_ack", ack, 0);
    exp_rd_q.push_back(ref_ptr[7:0]);
    read_bit(bt);
    check_eq("rst_bit7", bt, 0);
    wq();
    check_eq("sda_low_pre_reset", sda_bus, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("sda_released", sda_bus, 1);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    ref_ptr = 16'h0000;
    check_strobes();
    wq();

    // Fresh START after reset decodes normally.
    tx_data.push_back(8'($urandom));
    tx_data.push_back(8'($urandom));
    txn_write(16'($urandom));
    txn_read(1'b0, 16'h0000, 1);
    check_strobes();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
